// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the core's fetch/data ports, the
// arbiter and the shared memory. The slave modport is the arbiter's view.
// The master modport is the environment's view, i.e. the core plus the memory.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // fetch port
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    // data port
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_data;
    logic            dmem_req_fcn;
    logic [2:0]      dmem_req_typ;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_data;
    // memory side
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic [XLEN-1:0] mem_req_data;
    logic            mem_req_fcn;
    logic [2:0]      mem_req_typ;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_fcn, dmem_req_typ,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_fcn, dmem_req_typ,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch
// and data ports. It handles one transaction at a time, and a watchdog aborts
// a transaction whose response never arrives.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,  // 0 disables the watchdog
    parameter int CNT_W   = 8     // TIMEOUT < 2**CNT_W
) (
    input  logic             clk,
    input  logic             rst,   // async, active low
    mem_arbiter_if.slave     bus,
    output logic             busy,
    output logic             bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_data;
    logic              lat_fcn;
    logic [2:0]        lat_typ;

    logic              any_req;
    logic              pick_d;
    logic              grant;
    logic              resp_hit;
    logic              wd_hit;
    logic              done;
    logic [XLEN-1:0]   resp_data;

    // Grant selection, response routing and watchdog abort detection.
    // The grant is gated by rst so that every output stays low while reset is held.
    always_comb begin
        any_req   = bus.imem_req_valid || bus.dmem_req_valid;
        pick_d    = bus.dmem_req_valid && (!bus.imem_req_valid || last_grant == OWN_I);
        grant     = rst && (state == IDLE) && any_req;
        resp_hit  = (state == WAIT) && bus.mem_resp_valid;
        wd_hit    = (TIMEOUT != 0) && (state == REQ || state == WAIT) &&
                    (cnt == TO_LAST) && !resp_hit;
        done      = resp_hit || wd_hit;
        resp_data = resp_hit ? bus.mem_resp_data : '0;

        bus.imem_req_ready  = grant && !pick_d;
        bus.dmem_req_ready  = grant && pick_d;
        bus.imem_resp_valid = done && (owner == OWN_I);
        bus.dmem_resp_valid = done && (owner == OWN_D);
        bus.imem_resp_data  = (done && owner == OWN_I) ? resp_data : '0;
        bus.dmem_resp_data  = (done && owner == OWN_D) ? resp_data : '0;

        bus.mem_req_valid = (state == REQ);
        bus.mem_req_addr  = lat_addr;
        bus.mem_req_data  = lat_data;
        bus.mem_req_fcn   = lat_fcn;
        bus.mem_req_typ   = lat_typ;

        busy    = (state != IDLE);
        bus_err = wd_hit;
    end

    // Transaction FSM: latch the winner's request, issue it to memory, wait for response or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_D;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_fcn    <= 1'b0;
            lat_typ    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= pick_d;
                        last_grant <= pick_d;
                        cnt        <= '0;
                        state      <= REQ;
                        if (pick_d) begin
                            lat_addr <= bus.dmem_req_addr;
                            lat_data <= bus.dmem_req_data;
                            lat_fcn  <= bus.dmem_req_fcn;
                            lat_typ  <= bus.dmem_req_typ;
                        end else begin
                            // fetches are always word loads
                            lat_addr <= bus.imem_req_addr;
                            lat_data <= '0;
                            lat_fcn  <= 1'b0;
                            lat_typ  <= 3'b010;
                        end
                    end
                end
                REQ: begin
                    cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    if (wd_hit)
                        state <= IDLE;
                    else if (bus.mem_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    if (done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The main instance uses TIMEOUT=8. A second
// instance with the watchdog disabled shares the same inputs.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, bus_err, busy_z, bus_err_z;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.XLEN(32)) ifa ();
    mem_arbiter_if #(.XLEN(32)) ifz ();

    mem_arbiter #(.XLEN(32), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(ifa.slave), .busy(busy), .bus_err(bus_err));

    mem_arbiter #(.XLEN(32), .TIMEOUT(0), .CNT_W(8)) dut_z (
        .clk(clk), .rst(rst), .bus(ifz.slave), .busy(busy_z), .bus_err(bus_err_z));

    assign ifz.imem_req_valid = ifa.imem_req_valid;
    assign ifz.imem_req_addr  = ifa.imem_req_addr;
    assign ifz.dmem_req_valid = ifa.dmem_req_valid;
    assign ifz.dmem_req_addr  = ifa.dmem_req_addr;
    assign ifz.dmem_req_data  = ifa.dmem_req_data;
    assign ifz.dmem_req_fcn   = ifa.dmem_req_fcn;
    assign ifz.dmem_req_typ   = ifa.dmem_req_typ;
    assign ifz.mem_req_ready  = ifa.mem_req_ready;
    assign ifz.mem_resp_valid = ifa.mem_resp_valid;
    assign ifz.mem_resp_data  = ifa.mem_resp_data;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.imem_req_valid = 1'b1;
        ifa.imem_req_addr  = '0;
        ifa.dmem_req_valid = 1'b1;
        ifa.dmem_req_addr  = '0;
        ifa.dmem_req_data  = '0;
        ifa.dmem_req_fcn   = 1'b0;
        ifa.dmem_req_typ   = 3'b010;
        ifa.mem_req_ready  = 1'b0;
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'hFFFF_FFFF;

        // reset state: requests and a stray response present, all outputs must stay low
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_i_ready", 32'(ifa.imem_req_ready), 0);
        chk("rst_d_ready", 32'(ifa.dmem_req_ready), 0);
        chk("rst_i_resp", 32'(ifa.imem_resp_valid), 0);
        chk("rst_mreq_valid", 32'(ifa.mem_req_valid), 0);
        chk("rst_mreq_typ", 32'(ifa.mem_req_typ), 0);
        tick();
        ifa.imem_req_valid = 1'b0;
        ifa.dmem_req_valid = 1'b0;
        ifa.mem_resp_valid = 1'b0;
        rst = 1'b1;

        // fetch only, zero-wait memory
        ifa.imem_req_valid = 1'b1;
        ifa.imem_req_addr  = 32'h200;
        ifa.mem_req_ready  = 1'b1;
        @(negedge clk);
        chk("f_i_ready_T", 32'(ifa.imem_req_ready), 1);
        chk("f_d_ready_T", 32'(ifa.dmem_req_ready), 0);
        chk("f_busy_T", 32'(busy), 0);
        tick();
        ifa.imem_req_valid = 1'b0;
        ifa.imem_req_addr  = 32'hBAD0;
        @(negedge clk);
        chk("f_mreq_valid", 32'(ifa.mem_req_valid), 1);
        chk("f_mreq_addr", ifa.mem_req_addr, 32'h200);
        chk("f_mreq_typ", 32'(ifa.mem_req_typ), 32'b010);
        chk("f_mreq_fcn", 32'(ifa.mem_req_fcn), 0);
        chk("f_mreq_data", ifa.mem_req_data, 0);
        chk("f_busy_T1", 32'(busy), 1);
        tick();
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'h0000_0013;
        @(negedge clk);
        chk("f_i_resp", 32'(ifa.imem_resp_valid), 1);
        chk("f_i_data", ifa.imem_resp_data, 32'h13);
        chk("f_d_resp", 32'(ifa.dmem_resp_valid), 0);
        chk("f_d_data", ifa.dmem_resp_data, 0);
        tick();
        ifa.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("f_busy_T3", 32'(busy), 0);
        chk("f_i_resp_T3", 32'(ifa.imem_resp_valid), 0);

        // reset pulse, then both requesters valid every cycle: grants alternate I,D,I,D
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ifa.imem_req_valid = 1'b1;
        ifa.imem_req_addr  = 32'h100;
        ifa.dmem_req_valid = 1'b1;
        ifa.dmem_req_addr  = 32'h8000;
        ifa.dmem_req_data  = 32'h0;
        ifa.dmem_req_fcn   = 1'b0;
        ifa.dmem_req_typ   = 3'b010;
        for (int k = 0; k < 4; k++) begin
            logic ed;
            ed = k[0];
            @(negedge clk);
            chk($sformatf("rr%0d_i_ready", k), 32'(ifa.imem_req_ready), 32'(!ed));
            chk($sformatf("rr%0d_d_ready", k), 32'(ifa.dmem_req_ready), 32'(ed));
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d_mreq_addr", k), ifa.mem_req_addr, ed ? 32'h8000 : 32'h100);
            chk($sformatf("rr%0d_mreq_valid", k), 32'(ifa.mem_req_valid), 1);
            tick();
            ifa.mem_resp_valid = 1'b1;
            ifa.mem_resp_data  = 32'hA0 + 32'(k);
            @(negedge clk);
            chk($sformatf("rr%0d_i_resp", k), 32'(ifa.imem_resp_valid), 32'(!ed));
            chk($sformatf("rr%0d_d_resp", k), 32'(ifa.dmem_resp_valid), 32'(ed));
            chk($sformatf("rr%0d_i_data", k), ifa.imem_resp_data, ed ? 32'h0 : 32'hA0 + 32'(k));
            chk($sformatf("rr%0d_d_data", k), ifa.dmem_resp_data, ed ? 32'hA0 + 32'(k) : 32'h0);
            tick();
            ifa.mem_resp_valid = 1'b0;
        end
        ifa.imem_req_valid = 1'b0;
        ifa.dmem_req_valid = 1'b0;

        // store with 3 cycles of memory backpressure
        ifa.dmem_req_valid = 1'b1;
        ifa.dmem_req_addr  = 32'h8004;
        ifa.dmem_req_data  = 32'hDEAD_BEEF;
        ifa.dmem_req_fcn   = 1'b1;
        ifa.dmem_req_typ   = 3'b010;
        ifa.mem_req_ready  = 1'b0;
        @(negedge clk);
        chk("st_d_ready", 32'(ifa.dmem_req_ready), 1);
        tick();
        ifa.dmem_req_valid = 1'b0;
        ifa.dmem_req_addr  = 32'h1111;
        ifa.dmem_req_data  = 32'h2222;
        ifa.dmem_req_fcn   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("st_bp%0d_valid", c), 32'(ifa.mem_req_valid), 1);
            chk($sformatf("st_bp%0d_addr", c), ifa.mem_req_addr, 32'h8004);
            chk($sformatf("st_bp%0d_data", c), ifa.mem_req_data, 32'hDEAD_BEEF);
            chk($sformatf("st_bp%0d_fcn", c), 32'(ifa.mem_req_fcn), 1);
            tick();
        end
        ifa.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("st_accept_valid", 32'(ifa.mem_req_valid), 1);
        chk("st_no_early_ack", 32'(ifa.dmem_resp_valid), 0);
        tick();
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'h0;
        @(negedge clk);
        chk("st_ack", 32'(ifa.dmem_resp_valid), 1);
        chk("st_ack_i", 32'(ifa.imem_resp_valid), 0);
        tick();
        ifa.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("st_ack_once", 32'(ifa.dmem_resp_valid), 0);
        chk("st_idle", 32'(busy), 0);

        // stray responses in IDLE and in REQ are ignored
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'h7777;
        @(negedge clk);
        chk("sy_idle_i", 32'(ifa.imem_resp_valid), 0);
        chk("sy_idle_d", 32'(ifa.dmem_resp_valid), 0);
        chk("sy_idle_busy", 32'(busy), 0);
        tick();
        ifa.imem_req_valid = 1'b1;
        ifa.imem_req_addr  = 32'h400;
        ifa.mem_req_ready  = 1'b0;
        @(negedge clk);
        chk("sy_i_ready", 32'(ifa.imem_req_ready), 1);
        tick();
        ifa.imem_req_valid = 1'b0;
        @(negedge clk);
        chk("sy_req_i", 32'(ifa.imem_resp_valid), 0);
        chk("sy_req_d", 32'(ifa.dmem_resp_valid), 0);
        tick();
        @(negedge clk);
        chk("sy_still_req", 32'(ifa.mem_req_valid), 1);
        chk("sy_req_i2", 32'(ifa.imem_resp_valid), 0);
        ifa.mem_resp_valid = 1'b0;
        ifa.mem_req_ready  = 1'b1;
        tick();
        ifa.mem_req_ready  = 1'b0;
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'h55;
        @(negedge clk);
        chk("sy_real_resp", 32'(ifa.imem_resp_valid), 1);
        chk("sy_real_data", ifa.imem_resp_data, 32'h55);
        tick();
        ifa.mem_resp_valid = 1'b0;

        // watchdog: memory accepts but never responds
        ifa.dmem_req_valid = 1'b1;
        ifa.dmem_req_addr  = 32'h9000;
        ifa.dmem_req_fcn   = 1'b0;
        ifa.mem_req_ready  = 1'b1;
        ifa.mem_resp_data  = 32'h1234_5678;
        @(negedge clk);
        chk("wd_d_ready", 32'(ifa.dmem_req_ready), 1);
        tick();
        ifa.dmem_req_valid = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("wd_c%0d_err", c), 32'(bus_err), 0);
            chk($sformatf("wd_c%0d_resp", c), 32'(ifa.dmem_resp_valid), 0);
            tick();
        end
        @(negedge clk);
        chk("wd_err", 32'(bus_err), 1);
        chk("wd_d_resp", 32'(ifa.dmem_resp_valid), 1);
        chk("wd_d_data", ifa.dmem_resp_data, 0);
        chk("wd_i_resp", 32'(ifa.imem_resp_valid), 0);
        chk("wd0_err", 32'(bus_err_z), 0);
        chk("wd0_busy", 32'(busy_z), 1);
        tick();
        @(negedge clk);
        chk("wd_busy_after", 32'(busy), 0);
        chk("wd_err_once", 32'(bus_err), 0);
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
        chk("wd0_still_busy", 32'(busy_z), 1);
        chk("wd0_no_resp", 32'(ifz.dmem_resp_valid), 0);

        // reset asserted mid-transaction in WAIT
        tick();
        ifa.imem_req_valid = 1'b1;
        ifa.imem_req_addr  = 32'h300;
        tick();
        ifa.imem_req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("mr_in_wait", 32'(busy), 1);
        #1;
        rst = 1'b0;
        ifa.imem_req_valid = 1'b1;
        ifa.dmem_req_valid = 1'b1;
        ifa.mem_resp_valid = 1'b1;
        ifa.mem_resp_data  = 32'hFF;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_mreq_valid", 32'(ifa.mem_req_valid), 0);
        chk("mr_mreq_addr", ifa.mem_req_addr, 0);
        chk("mr_i_ready", 32'(ifa.imem_req_ready), 0);
        chk("mr_d_ready", 32'(ifa.dmem_req_ready), 0);
        chk("mr_i_resp", 32'(ifa.imem_resp_valid), 0);
        chk("mr_i_data", ifa.imem_resp_data, 0);
        chk("mr_bus_err", 32'(bus_err), 0);
        tick();
        ifa.mem_resp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_first_i", 32'(ifa.imem_req_ready), 1);
        chk("mr_first_d", 32'(ifa.dmem_req_ready), 0);
        tick();
        ifa.imem_req_valid = 1'b0;
        ifa.dmem_req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
